// File: rtl/modsq_pkg.sv
// modsq_pkg: shared definitions for the iterated modular-squaring engine.
//   state_t      - engine control states (IDLE, RUN)
//   MOD_LEN_DEF  - default operand/modulus width
//   MODULUS_DEF  - default odd modulus of MOD_LEN_DEF bits
//   calc_mod_sq  - behavioural (x * x) mod m on MOD_LEN_DEF-bit operands;
//                  narrower operands are zero-extended by the caller.
package modsq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MOD_LEN_DEF = 1024;

    // 2^1024 - 105: odd and full width, so every operand bit is exercised.
    localparam logic [MOD_LEN_DEF-1:0] MODULUS_DEF =
        {MOD_LEN_DEF{1'b1}} - MOD_LEN_DEF'(104);

    function automatic logic [MOD_LEN_DEF-1:0] calc_mod_sq(
        input logic [MOD_LEN_DEF-1:0] x,
        input logic [MOD_LEN_DEF-1:0] m
    );
        logic [2*MOD_LEN_DEF-1:0] prod;
        prod = {{MOD_LEN_DEF{1'b0}}, x} * {{MOD_LEN_DEF{1'b0}}, x};
        return MOD_LEN_DEF'(prod % {{MOD_LEN_DEF{1'b0}}, m});
    endfunction

endpackage

// File: rtl/modsq_core.sv
// modsq_core: one modular squaring with a fixed latency of PIPELINE_DEPTH
// cycles. This generation is a delay line behind a behavioural square; a
// pipelined multiplier can replace it behind the same ports.
//   clk       - clock, posedge
//   reset     - synchronous, active-high; drops all in-flight work
//   flush     - drops all in-flight work (abort path)
//   in_valid  - in_data is to be squared this cycle
//   in_data   - operand, < MODULUS
//   out_valid - out_data is a result this cycle
//   out_data  - (in_data * in_data) mod MODULUS, PIPELINE_DEPTH cycles later
// MOD_LEN must not exceed MOD_LEN_DEF.
module modsq_core
    import modsq_pkg::*;
#(
    parameter int                 MOD_LEN        = MOD_LEN_DEF,
    parameter logic [MOD_LEN-1:0] MODULUS        = MOD_LEN'(MODULUS_DEF),
    parameter int                 PIPELINE_DEPTH = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [MOD_LEN-1:0] in_data,
    output logic               out_valid,
    output logic [MOD_LEN-1:0] out_data
);

    logic [PIPELINE_DEPTH-1:0] vld_pipe;
    logic [MOD_LEN-1:0]        data_pipe [PIPELINE_DEPTH];
    logic [MOD_LEN-1:0]        sq_now;

    assign sq_now = MOD_LEN'(calc_mod_sq(MOD_LEN_DEF'(in_data),
                                         MOD_LEN_DEF'(MODULUS)));

    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples the pre-edge value of its neighbours, regardless of order.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[PIPELINE_DEPTH-2:0], in_valid};
        end
    end

    // NOTE: the data delay line is deliberately not reset; the valid bits
    // qualify it, and leaving wide storage without reset keeps it a plain
    // register file rather than a bank of resettable flops.
    always_ff @(posedge clk) begin
        data_pipe[0] <= sq_now;
        for (int i = 1; i < PIPELINE_DEPTH; i++) begin
            data_pipe[i] <= data_pipe[i-1];
        end
    end

    assign out_valid = vld_pipe[PIPELINE_DEPTH-1];
    assign out_data  = data_pipe[PIPELINE_DEPTH-1];

endmodule

// File: rtl/modular_square_iter.sv
// modular_square_iter: computes sq_in^(2^T) mod MODULUS by issuing T
// back-to-back squarings to modsq_core, feeding each result straight back.
//   clk        - clock, posedge
//   reset      - synchronous, active-high
//   start      - one-cycle request in IDLE; samples sq_in and iterations
//   abort      - cancels a run in progress (no done, no valid)
//   sq_in      - initial value, < MODULUS
//   iterations - number of squarings T
//   sq_out     - current result, meaningful only while valid is high
//   valid      - sq_out holds a result (every iteration if STREAM, else final)
//   iter_count - squarings completed in the current or last run
//   busy       - run in progress
//   done       - one-cycle pulse with the final result
module modular_square_iter
    import modsq_pkg::*;
#(
    parameter int                 MOD_LEN        = MOD_LEN_DEF,
    parameter logic [MOD_LEN-1:0] MODULUS        = MOD_LEN'(MODULUS_DEF),
    parameter int                 PIPELINE_DEPTH = 10,
    parameter int                 ITER_W         = 40,
    parameter bit                 STREAM         = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [MOD_LEN-1:0] sq_in,
    input  logic [ITER_W-1:0]  iterations,
    output logic [MOD_LEN-1:0] sq_out,
    output logic               valid,
    output logic [ITER_W-1:0]  iter_count,
    output logic               busy,
    output logic               done
);

    state_t             state;
    state_t             state_next;
    logic [ITER_W-1:0]  remaining;
    logic               last_iter;
    logic               core_in_valid;
    logic [MOD_LEN-1:0] core_in_data;
    logic               core_flush;
    logic               core_out_valid;
    logic [MOD_LEN-1:0] core_out_data;

    assign last_iter = (remaining == ITER_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Abort outranks a result arriving in the same cycle.
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && iterations != '0) state_next = RUN;
            RUN: begin
                if (abort)                            state_next = IDLE;
                else if (core_out_valid && last_iter) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output / issue logic. In RUN the next square is fed straight from the
    // core's result so iterations run with no bubble.
    always_comb begin
        busy          = 1'b0;
        core_in_valid = 1'b0;
        core_in_data  = sq_in;
        core_flush    = 1'b0;
        case (state)
            IDLE: core_in_valid = start && (iterations != '0);
            RUN: begin
                busy          = 1'b1;
                core_flush    = abort;
                core_in_valid = core_out_valid && !abort && !last_iter;
                core_in_data  = core_out_data;
            end
            default: ;
        endcase
    end

    // Control/status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid      <= 1'b0;
            done       <= 1'b0;
            iter_count <= '0;
            remaining  <= '0;
        end else begin
            valid <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        iter_count <= '0;
                        remaining  <= iterations;
                        if (iterations == '0) begin
                            valid <= 1'b1;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!abort && core_out_valid) begin
                        iter_count <= iter_count + ITER_W'(1);
                        remaining  <= remaining - ITER_W'(1);
                        if (last_iter) begin
                            valid <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            valid <= STREAM;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Current value; qualified by valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            sq_out <= sq_in;
        end else if (state == RUN && !abort && core_out_valid) begin
            sq_out <= core_out_data;
        end
    end

    modsq_core #(
        .MOD_LEN        (MOD_LEN),
        .MODULUS        (MODULUS),
        .PIPELINE_DEPTH (PIPELINE_DEPTH)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .flush     (core_flush),
        .in_valid  (core_in_valid),
        .in_data   (core_in_data),
        .out_valid (core_out_valid),
        .out_data  (core_out_data)
    );

endmodule

// File: tb/tb_modular_square_iter.sv
// Self-checking bench for modular_square_iter.
//   dut_s: 16-bit, MODULUS 65521, depth 4, STREAM=1  (functional + control)
//   dut_n: same, STREAM=0                            (final-only output)
//   dut_w: 1024-bit defaults, depth 10               (wide random run)
// Expected results are pushed to per-DUT queues at start and popped by
// negedge monitors whenever valid is seen.
module tb_modular_square_iter;
    import modsq_pkg::*;

    localparam int W16 = 16;
    localparam int IW  = 40;
    localparam logic [W16-1:0] M16 = 16'd65521;

    typedef struct {
        logic [1023:0] data;
        logic          done;
        logic [IW-1:0] iter;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q_s[$];
    exp_t q_n[$];
    exp_t q_w[$];

    // ---------------- DUT signals ----------------
    logic           rst_s, rst_c;
    logic           start_s, abort_s, start_n, abort_n, start_w, abort_w;
    logic [W16-1:0] sqin_s, sqin_n;
    logic [1023:0]  sqin_w;
    logic [IW-1:0]  iter_s, iter_n, iter_w;
    logic [W16-1:0] out_s, out_n;
    logic [1023:0]  out_w;
    logic           valid_s, valid_n, valid_w;
    logic           busy_s, busy_n, busy_w;
    logic           done_s, done_n, done_w;
    logic [IW-1:0]  ic_s, ic_n, ic_w;

    modular_square_iter #(
        .MOD_LEN(W16), .MODULUS(M16), .PIPELINE_DEPTH(4), .ITER_W(IW), .STREAM(1'b1)
    ) dut_s (
        .clk(clk), .reset(rst_s), .start(start_s), .abort(abort_s),
        .sq_in(sqin_s), .iterations(iter_s), .sq_out(out_s), .valid(valid_s),
        .iter_count(ic_s), .busy(busy_s), .done(done_s)
    );

    modular_square_iter #(
        .MOD_LEN(W16), .MODULUS(M16), .PIPELINE_DEPTH(4), .ITER_W(IW), .STREAM(1'b0)
    ) dut_n (
        .clk(clk), .reset(rst_c), .start(start_n), .abort(abort_n),
        .sq_in(sqin_n), .iterations(iter_n), .sq_out(out_n), .valid(valid_n),
        .iter_count(ic_n), .busy(busy_n), .done(done_n)
    );

    modular_square_iter dut_w (
        .clk(clk), .reset(rst_c), .start(start_w), .abort(abort_w),
        .sq_in(sqin_w), .iterations(iter_w), .sq_out(out_w), .valid(valid_w),
        .iter_count(ic_w), .busy(busy_w), .done(done_w)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [1023:0] got,
                         input logic [1023:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h (low 128 bits) at cycle %0d",
                     tag, got[127:0], exp[127:0], cyc);
        end
    endtask

    // Independent 16-bit reference square.
    function automatic logic [W16-1:0] ref_sq16(input logic [W16-1:0] x);
        longint p;
        p = longint'(x) * longint'(x);
        return W16'(p % longint'(M16));
    endfunction

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Start a run on dut_s from a negedge; pushes the first n_exp expected
    // streamed results (all of them for a complete run). Returns at cycle 1.
    task automatic kick_s(input logic [W16-1:0] v, input int t, input int n_exp,
                          output int c0);
        logic [W16-1:0] x;
        exp_t e;
        c0 = cyc;
        start_s = 1'b1;
        sqin_s  = v;
        iter_s  = IW'(t);
        if (t == 0) begin
            e.data = 1024'(v); e.done = 1'b1; e.iter = '0; e.cyc = c0 + 1;
            q_s.push_back(e);
        end
        x = v;
        for (int k = 1; k <= n_exp; k++) begin
            x = ref_sq16(x);
            e.data = 1024'(x); e.done = (k == t); e.iter = IW'(k); e.cyc = c0 + 4*k + 1;
            q_s.push_back(e);
        end
        @(negedge clk);
        start_s = 1'b0;
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin : mon_s
        exp_t e;
        if (!rst_s) begin
            if (valid_s) begin
                if (q_s.size() == 0) check("s_unexpected_valid", valid_s, 1'b0);
                else begin
                    e = q_s.pop_front();
                    check("s_data",  out_s,   e.data);
                    check("s_done",  done_s,  e.done);
                    check("s_iter",  ic_s,    e.iter);
                    check("s_cycle", cyc,     e.cyc);
                end
            end else if (done_s) check("s_done_without_valid", done_s, 1'b0);
        end
    end

    always @(negedge clk) begin : mon_n
        exp_t e;
        if (!rst_c) begin
            if (valid_n) begin
                if (q_n.size() == 0) check("n_unexpected_valid", valid_n, 1'b0);
                else begin
                    e = q_n.pop_front();
                    check("n_data",  out_n,  e.data);
                    check("n_done",  done_n, e.done);
                    check("n_iter",  ic_n,   e.iter);
                    check("n_cycle", cyc,    e.cyc);
                end
            end else if (done_n) check("n_done_without_valid", done_n, 1'b0);
        end
    end

    always @(negedge clk) begin : mon_w
        exp_t e;
        if (!rst_c) begin
            if (valid_w) begin
                if (q_w.size() == 0) check("w_unexpected_valid", valid_w, 1'b0);
                else begin
                    e = q_w.pop_front();
                    check("w_data",  out_w,  e.data);
                    check("w_done",  done_w, e.done);
                    check("w_iter",  ic_w,   e.iter);
                    check("w_cycle", cyc,    e.cyc);
                end
            end else if (done_w) check("w_done_without_valid", done_w, 1'b0);
        end
    end

    // Hard stop in case something blocks unexpectedly.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int            c0, c1, tw;
        logic [1023:0] xw;
        logic [W16-1:0] x16;
        exp_t          e;

        rst_s = 1'b1; rst_c = 1'b1;
        start_s = 1'b0; abort_s = 1'b0; sqin_s = '0; iter_s = '0;
        start_n = 1'b0; abort_n = 1'b0; sqin_n = '0; iter_n = '0;
        start_w = 1'b0; abort_w = 1'b0; sqin_w = '0; iter_w = '0;
        repeat (3) @(negedge clk);
        rst_s = 1'b0; rst_c = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_busy_s",  busy_s,  1'b0);
        check("rst_valid_s", valid_s, 1'b0);
        check("rst_done_s",  done_s,  1'b0);
        check("rst_iter_s",  ic_s,    '0);
        check("rst_busy_n",  busy_n,  1'b0);
        check("rst_busy_w",  busy_w,  1'b0);
        check("rst_iter_w",  ic_w,    '0);

        // Wide random run, T = 50, depth 10.
        for (int i = 0; i < 32; i++) xw[i*32 +: 32] = $urandom;
        xw = xw % MODULUS_DEF;
        tw = cyc;
        start_w = 1'b1; sqin_w = xw; iter_w = IW'(50);
        for (int k = 1; k <= 50; k++) begin
            xw = calc_mod_sq(xw, MODULUS_DEF);
            e.data = xw; e.done = (k == 50); e.iter = IW'(k); e.cyc = tw + 10*k + 1;
            q_w.push_back(e);
        end

        // sq_in = 3, T = 4 on both 16-bit engines (streaming and final-only).
        start_n = 1'b1; sqin_n = 16'd3; iter_n = IW'(4);
        x16 = 16'd3;
        for (int k = 1; k <= 4; k++) x16 = ref_sq16(x16);
        e.data = 1024'(x16); e.done = 1'b1; e.iter = IW'(4); e.cyc = cyc + 17;
        q_n.push_back(e);
        kick_s(16'd3, 4, 4, c0);
        start_w = 1'b0; start_n = 1'b0;
        check("s1_busy_c1", busy_s, 1'b1);
        check("n1_busy_c1", busy_n, 1'b1);
        check("w_busy_c1",  busy_w, 1'b1);
        wait_cyc(c0 + 16);
        check("s1_busy_c16", busy_s, 1'b1);
        wait_cyc(c0 + 17);
        check("s1_busy_done_cycle", busy_s, 1'b0);
        check("s1_iter_final", ic_s, IW'(4));
        check("n1_iter_final", ic_n, IW'(4));

        // T = 0 accepted in the done cycle: echo sq_in next cycle, never busy.
        kick_s(16'd1234, 0, 0, c0);
        check("t0_busy_c1", busy_s, 1'b0);
        @(negedge clk);
        check("t0_busy_c2", busy_s, 1'b0);
        check("t0_iter",    ic_s,   '0);

        // Start while busy is ignored; back-to-back start in the done cycle.
        kick_s(16'd5, 2, 2, c0);
        wait_cyc(c0 + 3);
        start_s = 1'b1; sqin_s = 16'd7; iter_s = IW'(1);
        @(negedge clk);
        start_s = 1'b0;
        wait_cyc(c0 + 9);
        kick_s(16'd11, 2, 2, c1);
        check("b2b_busy_c1", busy_s, 1'b1);
        wait_cyc(c1 + 9);

        // Abort at cycle 6 of a T = 4 run, with a simultaneous start.
        kick_s(16'd3, 4, 1, c0);
        wait_cyc(c0 + 6);
        abort_s = 1'b1; start_s = 1'b1; sqin_s = 16'd2; iter_s = IW'(1);
        @(negedge clk);
        abort_s = 1'b0; start_s = 1'b0;
        check("abort_busy_c7", busy_s, 1'b0);
        check("abort_iter_c7", ic_s,   IW'(1));
        wait_cyc(c0 + 25);
        check("abort_busy_late", busy_s, 1'b0);
        check("abort_iter_hold", ic_s,   IW'(1));

        // Reset at cycle 10 of a T = 4 run.
        kick_s(16'd3, 4, 2, c0);
        wait_cyc(c0 + 10);
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        check("midrst_busy",  busy_s,  1'b0);
        check("midrst_valid", valid_s, 1'b0);
        check("midrst_done",  done_s,  1'b0);
        check("midrst_iter",  ic_s,    '0);
        wait_cyc(c0 + 30);
        kick_s(16'd2, 1, 1, c1);
        wait_cyc(c1 + 6);
        check("post_rst_iter", ic_s, IW'(1));

        // Wide run completion.
        wait_cyc(tw + 500);
        check("w_busy_last", busy_w, 1'b1);
        wait_cyc(tw + 502);
        check("w_busy_after", busy_w, 1'b0);
        check("w_iter_final", ic_w,   IW'(50));

        check("s_queue_drained", q_s.size(), 0);
        check("n_queue_drained", q_n.size(), 0);
        check("w_queue_drained", q_w.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/modular_square_iter.md
# modular_square_iter

Parametrised iterated modular-squaring engine for the VDF evaluator: computes sq_in^(2^T) mod MODULUS for a runtime iteration count T, with a start/busy/done handshake, abort, and optional per-iteration result streaming. It sits between the host-facing control shell and a single-square datapath sub-module. It succeeds the fixed 1024-bit, free-running squaring loop with a bounded, restartable, width- and latency-generic engine.

## Interface
- MOD_LEN, 1024: operand/modulus width in bits.
- MODULUS, MOD_LEN'(`MODULUS_DEF): modulus; odd, > 1.
- PIPELINE_DEPTH, 10: cycles per squaring, ≥ 2.
- ITER_W, 40: width of iteration count.
- STREAM, 1: 1 = valid pulses on every iteration; 0 = valid on final result only.
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; samples sq_in and iterations.
- abort  in  1  cancel the run in progress.
- sq_in  in  MOD_LEN  initial value, must be < MODULUS.
- iterations  in  ITER_W  number of squarings T.
- sq_out  out  MOD_LEN  current result; X when valid is low.
- valid  out  1  sq_out holds a result this cycle.
- iter_count  out  ITER_W  squarings completed in the current or last run.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when the run completes (not on abort).

## Operation
- FSM states: IDLE, RUN. Reset → IDLE.
- IDLE + start, iterations == 0: stay IDLE; next cycle valid = done = 1, sq_out = sq_in unchanged, iter_count = 0.
- IDLE + start, iterations > 0: load cur = sq_in, remaining = iterations, iter_count = 0, issue square to the core; → RUN.
- RUN: when the core returns a result, cur ← result and iter_count increments. If iter_count reaches T → IDLE with done and valid pulsed. Otherwise valid pulses if STREAM = 1, and the next square is issued the same cycle.
- start while busy: ignored. abort while IDLE: ignored.
- abort in RUN: → IDLE next cycle; no done, no valid. The in-flight core result is discarded via the core flush. iter_count holds the completed count.
- abort and start in the same cycle while busy: abort wins; start is dropped.
- Arithmetic: result = (cur × cur) mod MODULUS using a 2·MOD_LEN-bit product; the result is always < MODULUS.
- Reset mid-run: returns to IDLE next cycle and flushes the core.
- Reset values: busy 0, done 0, valid 0, iter_count 0. sq_out is X while valid is low.

## Timing
- Start accepted in cycle 0.
- Iteration k result presented with valid high in cycle k·PIPELINE_DEPTH + 1.
- Final result: done and valid both high in cycle T·PIPELINE_DEPTH + 1.
- busy is high from cycle 1 through cycle T·PIPELINE_DEPTH and low in the done cycle.
- A new start is accepted in the done cycle itself; zero bubble between runs.
- Issue-to-result latency is exactly PIPELINE_DEPTH, independent of MOD_LEN.

## Structure
- Package modsq_pkg holds: the state enum (IDLE, RUN), the MOD_LEN_DEF/MODULUS_DEF defaults, and the helper function calc_mod_sq used by both the RTL and the bench.
- Sub-module modsq_core performs one squaring:
  - Ports: clk, reset, flush, in_valid, in_data, out_valid, out_data.
  - Fixed latency PIPELINE_DEPTH; in this generation a delay-line model around the behavioural modular square.
  - Later generations swap in the pipelined multiplier behind the same ports.
- The top level contains only the FSM, counters and output registers.

## Test plan
Scenarios 1–3 and 5 use MOD_LEN = 16, MODULUS = 65521, PIPELINE_DEPTH = 4; scenario 4 uses MOD_LEN = 1024 with default MODULUS.
1. sq_in = 3, T = 4, STREAM = 1 -> valid at cycles 5, 9, 13, 17 with 9, 81, 6561, 64945; done at cycle 17; iter_count = 4.
2. Same stimulus, STREAM = 0 -> single valid with done at cycle 17, sq_out = 64945.
3. T = 0, sq_in = 1234 -> cycle 1: valid = done = 1, sq_out = 1234, busy never high.
4. Random sq_in < MODULUS, T = 50 -> final sq_out matches calc_mod_sq applied 50 times; done at cycle 501.
5. Control corner cases:
   - abort at cycle 6 of a T = 4 run -> busy low from cycle 7, no done, iter_count = 1.
   - start during busy -> ignored.
   - reset at cycle 10 -> all outputs return to reset values.
   - back-to-back start in the done cycle -> second run's first valid 4·1 + 1 cycles later.
